// File: rtl/adat_pkg.sv
// adat_pkg - constants, types and the frame packing helper shared by the
// ADAT transmitter (and the future receiver).
//
// adat_pack_frame() returns the 256-bit frame in bit-index order
// (bit 0 is sent first).
package adat_pkg;

    localparam int ADAT_FRAME_BITS = 256;
    localparam int ADAT_SYNC_BITS  = 10;
    localparam int ADAT_CHANNELS   = 8;
    localparam int ADAT_SAMPLE_W   = 24;

    typedef logic [ADAT_SAMPLE_W-1:0]       adat_sample_t;
    typedef adat_sample_t [ADAT_CHANNELS-1:0] adat_frame_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } adat_tx_state_t;

    // Sync zeros, a 1, then (1,U3..U0), then 48 groups of (1, nibble):
    // channel 0 first, MSB nibble first, MSB first within a nibble.
    function automatic logic [ADAT_FRAME_BITS-1:0] adat_pack_frame(
        input adat_frame_t frame,
        input logic [3:0]  user
    );
        logic [ADAT_FRAME_BITS-1:0] v;
        v = '0;
        v[ADAT_SYNC_BITS] = 1'b1;
        v[11] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v[12 + i] = user[3 - i];
        end
        for (int g = 0; g < 48; g++) begin
            v[16 + 5*g] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                v[17 + 5*g + k] = frame[g/6][ADAT_SAMPLE_W - 1 - 4*(g%6) - k];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/adat_tx_stage.sv
// adat_tx_stage - 8 x 24-bit staging buffer for one ADAT frame.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   ch_data_i/valid  incoming sample stream
//   ch_ready_o       registered ready; low when full or in a swap cycle
//   swap_i           frame swap happening this clock
//   swap_next_i      frame swap will happen next clock (lets ready be registered)
//   frame_o          staged samples, index = channel
//   full_o           all 8 words staged
//   underrun_o       sticky, set by a swap that finds fewer than 8 words
module adat_tx_stage
    import adat_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [23:0]  ch_data_i,
    input  logic         ch_valid_i,
    output logic         ch_ready_o,
    input  logic         swap_i,
    input  logic         swap_next_i,
    output adat_frame_t  frame_o,
    output logic         full_o,
    output logic         underrun_o
);

    logic [3:0]  r_count;
    adat_frame_t r_frame;
    logic        r_ready;
    logic        r_underrun;

    logic        w_accept;
    logic [3:0]  w_count_nxt;

    assign w_accept = ch_valid_i && r_ready;

    // A swap empties the buffer; partial words are simply forgotten.
    always_comb begin
        w_count_nxt = r_count;
        if (swap_i) begin
            w_count_nxt = 4'd0;
        end else if (w_accept) begin
            w_count_nxt = r_count + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count    <= 4'd0;
            r_frame    <= '0;
            r_ready    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_accept && !swap_i) begin
                r_frame[r_count[2:0]] <= ch_data_i;
            end
            // Ready is computed one clock early so it is already low in the swap cycle.
            r_ready <= (w_count_nxt < 4'd8) && !swap_next_i;
            if (swap_i && (r_count != 4'd8)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign ch_ready_o = r_ready;
    assign frame_o    = r_frame;
    assign full_o     = (r_count == 4'd8);
    assign underrun_o = r_underrun;

endmodule

// File: rtl/adat_tx.sv
// adat_tx - single-lane ADAT optical transmitter.
//
// Ports:
//   clk_i          system clock (512*fs with CLKS_PER_BIT=2)
//   rst_i          synchronous active-high reset
//   enable_i       transmit enable
//   user_i         user bits U3..U0, latched at the frame swap
//   ch_data_i      channel sample, MSB first on the line
//   ch_valid_i     sample valid
//   ch_ready_o     staging buffer can take a word
//   frame_start_o  pulse while bit 0 of a frame is on the line
//   word_clk_o     high during bits 0..127
//   underrun_o     sticky underrun flag
//   adat_o         NRZI line output
//
// Build option ADAT_TX_UNDERRUN_REPEAT_EN: on underrun the previous samples
// are repeated instead of sending digital silence.
//
// state   | meaning
// ST_IDLE | enabled (or not) but no bit sent yet; next bit_ce swaps and starts bit 0
// ST_RUN  | frame in progress; swap happens on the 255->0 wrap
module adat_tx
    import adat_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [3:0]  user_i,
    input  logic [23:0] ch_data_i,
    input  logic        ch_valid_i,
    output logic        ch_ready_o,
    output logic        frame_start_o,
    output logic        word_clk_o,
    output logic        underrun_o,
    output logic        adat_o
);

    localparam logic [3:0] DIV_LAST = 4'(CLKS_PER_BIT - 1);

    logic           r_en;
    logic [3:0]     r_div;
    logic [7:0]     r_bit;
    adat_tx_state_t r_state;
    adat_frame_t    r_shift;
    logic [3:0]     r_user;
    logic           r_adat;
    logic           r_frame_start;
    logic           r_word_clk;

    logic           w_bit_ce;
    logic           w_swap;
    logic           w_swap_next;
    logic [3:0]     w_div_nxt;
    logic [7:0]     w_bit_nxt;
    adat_tx_state_t w_state_nxt;
    logic [ADAT_FRAME_BITS-1:0] w_frame_bits;
    logic           w_line_bit;
    adat_frame_t    w_stage_frame;
    logic           w_stage_full;

    assign w_bit_ce = r_en && (r_div == DIV_LAST);
    assign w_swap   = w_bit_ce && ((r_bit == 8'hFF) || (r_state == ST_IDLE));

    always_comb begin
        w_div_nxt   = 4'd0;
        w_bit_nxt   = 8'd0;
        w_state_nxt = ST_IDLE;
        if (r_en) begin
            w_div_nxt   = w_bit_ce ? 4'd0 : r_div + 4'd1;
            w_bit_nxt   = r_bit + {7'd0, w_bit_ce};
            w_state_nxt = w_bit_ce ? ST_RUN : r_state;
        end
    end

    // r_en follows enable_i, so enable_i is exactly next clock's r_en and the
    // swap can be predicted a clock ahead for the registered ready.
    assign w_swap_next = enable_i && (w_div_nxt == DIV_LAST) &&
                         ((w_bit_nxt == 8'hFF) || (w_state_nxt == ST_IDLE));

    assign w_frame_bits = adat_pack_frame(r_shift, r_user);
    assign w_line_bit   = w_frame_bits[r_bit];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en          <= 1'b0;
            r_div         <= 4'd0;
            r_bit         <= 8'd0;
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_user        <= 4'd0;
            r_adat        <= 1'b0;
            r_frame_start <= 1'b0;
            r_word_clk    <= 1'b0;
        end else begin
            r_en          <= enable_i;
            r_div         <= w_div_nxt;
            r_bit         <= w_bit_nxt;
            r_state       <= w_state_nxt;
            r_frame_start <= w_bit_ce && (r_bit == 8'd0);
            if (w_bit_ce) begin
                r_adat <= r_adat ^ w_line_bit;
            end
            if (!r_en) begin
                r_word_clk <= 1'b0;
            end else if (w_bit_ce) begin
                r_word_clk <= ~r_bit[7];
            end
            // Bit 255 of the old frame is sent from the old buffer in this same clock.
            if (w_swap) begin
                r_user <= user_i;
                if (w_stage_full) begin
                    r_shift <= w_stage_frame;
                end else begin
`ifdef ADAT_TX_UNDERRUN_REPEAT_EN
                    r_shift <= r_shift;
`else
                    r_shift <= '0;
`endif
                end
            end
        end
    end

    adat_tx_stage u_stage (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ch_data_i   (ch_data_i),
        .ch_valid_i  (ch_valid_i),
        .ch_ready_o  (ch_ready_o),
        .swap_i      (w_swap),
        .swap_next_i (w_swap_next),
        .frame_o     (w_stage_frame),
        .full_o      (w_stage_full),
        .underrun_o  (underrun_o)
    );

    assign adat_o        = r_adat;
    assign frame_start_o = r_frame_start;
    assign word_clk_o    = r_word_clk;

endmodule

// File: tb/tb_adat_tx.sv
module tb_adat_tx;

    localparam int HUGE = 1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  user;
    logic [23:0] ch_data;
    logic        ch_valid;

    logic ready0, fs0, wc0, ur0, adat0;
    logic ready1, fs1, wc1, ur1, adat1;

    always #5 clk = ~clk;

    adat_tx #(.CLKS_PER_BIT(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .user_i(user),
        .ch_data_i(ch_data), .ch_valid_i(ch_valid), .ch_ready_o(ready0),
        .frame_start_o(fs0), .word_clk_o(wc0), .underrun_o(ur0), .adat_o(adat0)
    );

    adat_tx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .user_i(user),
        .ch_data_i(ch_data), .ch_valid_i(ch_valid), .ch_ready_o(ready1),
        .frame_start_o(fs1), .word_clk_o(wc1), .underrun_o(ur1), .adat_o(adat1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bits_msb_first(input logic [255:0] v, input int lo, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], v[lo + i]};
        return r;
    endfunction

    function automatic int ones(input logic [255:0] v, input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) c += int'(v[i]);
        return c;
    endfunction

    // Source feeder: decides at each negedge, using the (stable) registered ready.
    logic [23:0] src [8];
    int   idx   = 0;
    int   quota = 0;
    int   n_acc = 0;
    logic pend  = 1'b0;

    initial begin
        ch_valid = 1'b0;
        ch_data  = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                n_acc++;
                idx = (idx + 1) % 8;
                if (quota > 0) quota--;
            end
            ch_valid = (quota > 0);
            ch_data  = src[idx];
            pend     = ch_valid && ready0;
        end
    end

    // Line monitor for the CLKS_PER_BIT=2 instance.
    int   n_fs = 0, t0 = -1, tog0 = 0, wcn0 = 0;
    int   last_period = 0, last_tog = 0, last_wc = 0;
    logic [255:0] cap0 = '0, last_cap = '0;
    logic prev_adat = 1'b0;
    logic [4:0] rdy_h = '0, ur_h = '0;
    logic fs_rdy_m3 = 1'b0, fs_rdy_m2 = 1'b0, fs_ur_m4 = 1'b0, fs_ur_m2 = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            rdy_h = {rdy_h[3:0], ready0};
            ur_h  = {ur_h[3:0], ur0};
            if (rst) begin
                t0 = -1;
            end else begin
                if (fs0) begin
                    if (t0 >= 0) begin
                        last_cap = cap0; last_period = t0; last_tog = tog0; last_wc = wcn0;
                    end
                    fs_rdy_m3 = rdy_h[3]; fs_rdy_m2 = rdy_h[2];
                    fs_ur_m4  = ur_h[4];  fs_ur_m2  = ur_h[2];
                    n_fs++; t0 = 0; cap0 = '0; tog0 = 0; wcn0 = 0;
                end
                if (t0 >= 0) begin
                    if ((t0 % 2 == 0) && (t0 < 512)) cap0[t0/2] = (adat0 != prev_adat);
                    if (adat0 != prev_adat) tog0++;
                    if (wc0) wcn0++;
                    t0++;
                end
            end
            prev_adat = adat0;
        end
    end

    // Timing monitor for the CLKS_PER_BIT=1 instance.
    int t1 = -1, wcn1 = 0, last_period1 = 0, last_wc1 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                t1 = -1;
            end else begin
                if (fs1) begin
                    if (t1 >= 0) begin last_period1 = t1; last_wc1 = wcn1; end
                    t1 = 0; wcn1 = 0;
                end
                if (t1 >= 0) begin
                    if (wc1) wcn1++;
                    t1++;
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_fs(input int n);
        int target;
        target = n_fs + n;
        for (int k = 0; k < 600 * n + 50 && n_fs < target; k++) wait_clks(1);
        check_val("wait_frame_start", n_fs, target);
    endtask

    task automatic wait_acc(input int target);
        for (int k = 0; k < 100 && n_acc < target; k++) wait_clks(1);
        check_val("stage_fill", n_acc, target);
    endtask

    task automatic enable_and_check_latency(input string tag);
        int k;
        enable = 1'b1;
        k = 0;
        do begin
            wait_clks(1);
            k++;
        end while (!fs0 && k < 20);
        check_val(tag, k, 3);
    endtask

    initial begin
        int a0;
        int ur_ones;
        rst = 1'b1; enable = 1'b0; user = 4'h0;
        for (int i = 0; i < 8; i++) src[i] = '0;

        // Reset state
        wait_clks(3);
        check_val("rst_adat", adat0, 0);
        check_val("rst_frame_start", fs0, 0);
        check_val("rst_word_clk", wc0, 0);
        check_val("rst_underrun", ur0, 0);
        check_val("rst_ready", ready0, 0);
        rst = 1'b0;
        wait_clks(1);
        check_val("ready_after_rst", ready0, 1);

        // Silence
        quota = HUGE;
        wait_acc(8);
        enable_and_check_latency("first_fs_latency");
        wait_fs(1);
        check_val("sil_period", last_period, 512);
        check_val("sil_toggles", last_tog, 50);
        check_val("sil_word_clk", last_wc, 256);
        check_val("sil_head", bits_msb_first(last_cap, 0, 16), 32'b0000000000110000);
        check_val("sil_underrun", ur0, 0);
        check_val("div1_period", last_period1, 256);
        check_val("div1_word_clk", last_wc1, 128);

        // Channel 0 pattern
        wait_clks(16);
        src[0] = 24'hA5F00F;
        user   = 4'hC;
        wait_fs(3);
        check_val("pat_sync", bits_msb_first(last_cap, 0, 11), 32'b00000000001);
        check_val("pat_user", bits_msb_first(last_cap, 11, 5), 32'b11100);
        check_val("pat_ch0", bits_msb_first(last_cap, 16, 30), 32'b110101010111111100001000011111);
        check_val("pat_rest_ones", ones(last_cap, 46, 255), 42);
        check_val("pat_period", last_period, 512);

        // Underrun: 7 words for the frame after next
        wait_clks(16);
        check_val("ur_before", ur0, 0);
        quota = 7;
        user  = 4'h3;
        wait_fs(2);
        check_val("ur_pre_swap", fs_ur_m4, 0);
        check_val("ur_post_swap", fs_ur_m2, 1);
        wait_fs(1);
`ifdef ADAT_TX_UNDERRUN_REPEAT_EN
        ur_ones = 60;
`else
        ur_ones = 48;
`endif
        check_val("ur_frame_ones", ones(last_cap, 16, 255), ur_ones);
        check_val("ur_user", bits_msb_first(last_cap, 12, 4), 32'h3);
        check_val("ur_sticky", ur0, 1);

        // Backpressure: valid held high
        idx   = 0;
        quota = HUGE;
        wait_fs(1);
        for (int f = 0; f < 2; f++) begin
            a0 = n_acc;
            wait_fs(1);
            check_val("bp_accepts", n_acc - a0, 8);
            check_val("bp_ready_swap", fs_rdy_m3, 0);
            check_val("bp_ready_after", fs_rdy_m2, 1);
            check_val("bp_frame_ones", ones(last_cap, 16, 255), 60);
        end

        // Reset mid-frame at bit 100
        wait_clks(196);
        quota = 0;
        wait_clks(4);
        check_val("mid_word_clk_high", wc0, 1);
        rst = 1'b1; enable = 1'b0;
        wait_clks(1);
        check_val("mid_rst_adat", adat0, 0);
        check_val("mid_rst_frame_start", fs0, 0);
        check_val("mid_rst_word_clk", wc0, 0);
        check_val("mid_rst_underrun", ur0, 0);
        check_val("mid_rst_ready", ready0, 0);
        rst = 1'b0;
        wait_clks(1);
        check_val("mid_ready_after", ready0, 1);
        idx   = 0;
        a0    = n_acc;
        quota = HUGE;
        wait_acc(a0 + 8);
        enable_and_check_latency("restart_fs_latency");
        wait_fs(1);
        check_val("restart_period", last_period, 512);
        check_val("restart_frame_ones", ones(last_cap, 16, 255), 60);
        check_val("restart_underrun", ur0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adat_tx.md
# adat_tx

Single-lane ADAT optical transmitter. Accepts eight 24-bit channel samples per frame over a valid/ready stream, serialises them with the 4 user bits into the 256-bit ADAT frame, and drives the NRZI-encoded line. One instance per output lane feeds `adat_out_1_o` and `adat_out_2_o` in `main`; it runs on the selected xtal clock.

## Interface
- `CLKS_PER_BIT`, default 2: clocks per ADAT bit. 2 matches the 512·fs xtal clocks. Legal range 1..16.
- `clk_i` input 1: system clock, 512·fs when `CLKS_PER_BIT`=2.
- `rst_i` input 1: synchronous, active-high reset.
- `enable_i` input 1: transmit enable.
- `user_i` input 4: ADAT user bits U3..U0, sampled at the frame swap.
- `ch_data_i` input 24: channel sample, MSB first on the line.
- `ch_valid_i` input 1: `ch_data_i` valid.
- `ch_ready_o` output 1: staging buffer can accept a word.
- `frame_start_o` output 1: one-cycle pulse when bit 0 of a frame is on the line.
- `word_clk_o` output 1: fs word clock, high during bits 0..127.
- `underrun_o` output 1: sticky; set when a frame swap finds fewer than 8 staged words.
- `adat_o` output 1: NRZI line output.

## Operation
- **Frame layout**, 256 bits in bit-index order:
  - Bits 0..9: 0 (sync).
  - Bit 10: 1.
  - Bits 11..15: 1, U3, U2, U1, U0.
  - Bits 16..255: 48 groups of (1, nibble). Channel 0 goes first, each sample's nibbles MSB nibble first, bits MSB first.
- **NRZI encoding:** `adat_o` toggles on every 1 bit and holds on every 0 bit.
- **Bit timing:**
  - A divider produces bit strobe `bit_ce` every `CLKS_PER_BIT` clocks.
  - An 8-bit bit counter advances on `bit_ce` and wraps 255→0.
- **Staging buffer:**
  - 8×24 words plus a 4-bit fill count.
  - A word is accepted when `ch_valid_i && ch_ready_o`, written at index = count, and count increments.
  - `ch_ready_o` = (count < 8) and not swap cycle. It is registered.
- **Swap** occurs on the clock where the counter wraps to 0, or on the first `bit_ce` after `enable_i` rises:
  - If count == 8: copy staging to the shift buffer and clear count.
  - If count < 8: set `underrun_o`, clear count, and discard the partial words.
  - Latch `user_i` into the frame.
- **Disabled:** `enable_i` low holds the divider and counter at 0 and holds the `adat_o` level. `frame_start_o` and `word_clk_o` are 0. Staging still accepts words.
- **Reset:**
  - `adat_o`, `frame_start_o`, `word_clk_o`, `underrun_o` and `ch_ready_o` are 0.
  - Counters are 0, count is 0 and the shift buffer is zero.
  - `ch_ready_o` rises on the first clock after `rst_i` is deasserted.
  - Reset mid-frame truncates the frame immediately; no partial-frame completion.
- `underrun_o` is cleared only by `rst_i`.

## Timing
- `adat_o` is registered. A bit is applied one clock after its `bit_ce`, and each bit lasts `CLKS_PER_BIT` clocks.
- `frame_start_o` is asserted in the same clock that bit 0 first appears on `adat_o`.
- Frame period is 256·`CLKS_PER_BIT` clocks.
- In the swap cycle, `ch_ready_o` is forced 0. Words presented that cycle are held off by the handshake, never dropped.
- Upstream must deliver 8 words within one frame period. A word accepted after a swap belongs to the next frame.

## Configuration
- **Macro: `ADAT_TX_UNDERRUN_REPEAT_EN`.**
- Defined: on underrun, the shift buffer keeps the previous frame's samples, so the previous audio is repeated. User bits are still updated.
- Undefined: on underrun, the shift buffer loads all zeros (digital silence).
- `underrun_o` behaves identically in both builds.

## Structure
- **Package `adat_pkg`:**
  - Constants: `ADAT_FRAME_BITS`=256, `ADAT_SYNC_BITS`=10, `ADAT_CHANNELS`=8, `ADAT_SAMPLE_W`=24.
  - Typedefs: `adat_sample_t` (logic [23:0]) and `adat_frame_t` (array of 8 samples).
  - Shared with the future `adat_rx`.
- **Sub-module `adat_tx_stage`:** staging buffer with fill count, ready logic and swap/underrun output. The bit sequencer and NRZI stay in `adat_tx`.

## Test plan
- **Silence:** `CLKS_PER_BIT`=2, user 0, all samples 0, fed continuously. Expect exactly 50 `adat_o` toggles per 512-clock frame and `frame_start_o` every 512 clocks.
- **Channel 0 pattern:** ch0=24'hA5F00F, others 0, user 4'hC. Decode NRZI from `frame_start_o`. Bits 11..15 = 1,1,1,0,0; bits 16..45 = 1,1010,1,0101,1,1111,1,0000,1,0000,1,1111.
- **Underrun:** only 7 words supplied before the swap. Expect `underrun_o`=1 from the swap clock onward and the next frame's data zero. With `ADAT_TX_UNDERRUN_REPEAT_EN`, the next frame instead repeats the previous samples.
- **Backpressure:** `ch_valid_i` held high constantly. Expect exactly 8 accepts per frame and `ch_ready_o`=0 in each swap cycle.
- **Divider:** `CLKS_PER_BIT`=1. Expect `frame_start_o` period 256 clocks and `word_clk_o` high for 128 clocks.
- **Reset mid-frame:** assert `rst_i` at bit 100 for 1 clock. Expect all outputs 0 next clock and `ch_ready_o`=1 the clock after. Once 8 words are supplied, the first frame begins with `frame_start_o` after the first `bit_ce`.
